// File: rtl/mdu_dispatch_pkg.sv
// ============================================================================
// Module  : mdu_dispatch_pkg
// Brief   : Shared MDU operation codes and pending-slot state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mdu_dispatch_pkg;

    localparam logic [2:0] mtNone             = 3'd0;
    localparam logic [2:0] mtMultiply         = 3'd1;
    localparam logic [2:0] mtMultiplyUnsigned = 3'd2;
    localparam logic [2:0] mtDivide           = 3'd3;
    localparam logic [2:0] mtDivideUnsigned   = 3'd4;
    localparam logic [2:0] mtSetHI            = 3'd5;
    localparam logic [2:0] mtSetLO            = 3'd6;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Codes the MDU actually executes; everything else is dropped at dispatch.
    function automatic logic is_mdu_op(input logic [2:0] op);
        logic r_ok;
        r_ok = 1'b0;
        case (op)
            mtMultiply, mtMultiplyUnsigned, mtDivide,
            mtDivideUnsigned, mtSetHI, mtSetLO: r_ok = 1'b1;
            default:                            r_ok = 1'b0;
        endcase
        return r_ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_pending_slot.sv
// ============================================================================
// Module  : mdu_pending_slot
// Brief   : One-entry holding register for an MDU request awaiting issue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_pending_slot
    import mdu_dispatch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_capture,
    input  logic        i_release,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_full,
    output logic [2:0]  o_op,
    output logic [31:0] o_a,
    output logic [31:0] o_b
);

    slot_state_e r_state;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    // Capture wins over release: issuing the old entry and taking a new one
    // in the same cycle leaves the slot occupied by the new entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
            r_op    <= mtNone;
            r_a     <= '0;
            r_b     <= '0;
        end else if (i_capture) begin
            r_state <= SLOT_FULL;
            r_op    <= i_op;
            r_a     <= i_a;
            r_b     <= i_b;
        end else if (i_release) begin
            r_state <= SLOT_EMPTY;
        end
    end

    assign o_full = (r_state == SLOT_FULL);
    assign o_op   = r_op;
    assign o_a    = r_a;
    assign o_b    = r_b;

endmodule

`default_nettype wire

// File: rtl/mdu_dispatch.sv
// ============================================================================
// Module  : mdu_dispatch
// Brief   : Issue/hazard stage between EX and the HI/LO multiply-divide unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_dispatch
    import mdu_dispatch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ex_mdu_valid,
    input  logic [2:0]  i_ex_op,
    input  logic [31:0] i_ex_a,
    input  logic [31:0] i_ex_b,
    input  logic        i_ex_hilo_read,
    input  logic        i_ex_read_hi,
    input  logic        i_flush,
    output logic        o_stall,
    output logic [31:0] o_rd_data,
    output logic        o_mdu_start,
    output logic [2:0]  o_mdu_ctrl,
    output logic [31:0] o_mdu_a,
    output logic [31:0] o_mdu_b,
    input  logic        i_mdu_busy,
    input  logic [31:0] i_mdu_hi,
    input  logic [31:0] i_mdu_lo
);

    logic        w_req;
    logic        w_issue_ok;
    logic        w_slot_full;
    logic        w_issue_pend;
    logic        w_issue_bypass;
    logic        w_capture;
    logic [2:0]  w_slot_op;
    logic [31:0] w_slot_a;
    logic [31:0] w_slot_b;

    logic        r_mdu_start;
    logic [2:0]  r_mdu_ctrl;
    logic [31:0] r_mdu_a;
    logic [31:0] r_mdu_b;

    assign w_req = i_ex_mdu_valid && !i_flush && is_mdu_op(i_ex_op);

    // The start term keeps one idle cycle between starts: busy is not yet
    // visible in the cycle after a start, and mthi/mtlo must not overtake.
    assign w_issue_ok = !i_mdu_busy && !r_mdu_start;

    assign w_issue_pend   = w_slot_full && w_issue_ok;
    assign w_issue_bypass = !w_slot_full && w_req && w_issue_ok;
    assign w_capture      = (w_issue_pend && w_req)
                          || (!w_slot_full && w_req && !w_issue_ok);

    mdu_pending_slot u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_capture (w_capture),
        .i_release (w_issue_pend),
        .i_op      (i_ex_op),
        .i_a       (i_ex_a),
        .i_b       (i_ex_b),
        .o_full    (w_slot_full),
        .o_op      (w_slot_op),
        .o_a       (w_slot_a),
        .o_b       (w_slot_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdu_start <= 1'b0;
            r_mdu_ctrl  <= mtNone;
            r_mdu_a     <= '0;
            r_mdu_b     <= '0;
        end else begin
            r_mdu_start <= w_issue_pend || w_issue_bypass;
            if (w_issue_pend) begin
                r_mdu_ctrl <= w_slot_op;
                r_mdu_a    <= w_slot_a;
                r_mdu_b    <= w_slot_b;
            end else if (w_issue_bypass) begin
                r_mdu_ctrl <= i_ex_op;
                r_mdu_a    <= i_ex_a;
                r_mdu_b    <= i_ex_b;
            end
        end
    end

    // HI/LO are final only once nothing is in flight or waiting to issue.
    assign o_stall = (w_req && w_slot_full && !w_issue_ok)
                   || (i_ex_hilo_read && !i_flush
                       && (i_mdu_busy || r_mdu_start || w_slot_full));

    assign o_rd_data   = i_ex_read_hi ? i_mdu_hi : i_mdu_lo;
    assign o_mdu_start = r_mdu_start;
    assign o_mdu_ctrl  = r_mdu_ctrl;
    assign o_mdu_a     = r_mdu_a;
    assign o_mdu_b     = r_mdu_b;

endmodule

`default_nettype wire

// File: tb/tb_mdu_dispatch.sv
// ============================================================================
// Module  : tb_mdu_dispatch
// Brief   : Self-checking bench with MDU environment and FIFO reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mdu_dispatch;
    import mdu_dispatch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_mdu_valid, ex_hilo_read, ex_read_hi, flush;
    logic [2:0]  ex_op;
    logic [31:0] ex_a, ex_b;
    logic        stall, mdu_start, mdu_busy;
    logic [31:0] rd_data, mdu_A, mdu_B, mdu_HI, mdu_LO;
    logic [2:0]  mdu_ctrl;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    op_t         q[$];
    logic        m_start = 1'b0;
    logic [2:0]  m_ctrl  = 3'd0;
    logic [31:0] m_a = 32'd0, m_b = 32'd0;
    logic [31:0] arch_hi = 32'd0, arch_lo = 32'd0;

    always #5 clk = ~clk;

    mdu_dispatch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_ex_mdu_valid (ex_mdu_valid),
        .i_ex_op        (ex_op),
        .i_ex_a         (ex_a),
        .i_ex_b         (ex_b),
        .i_ex_hilo_read (ex_hilo_read),
        .i_ex_read_hi   (ex_read_hi),
        .i_flush        (flush),
        .o_stall        (stall),
        .o_rd_data      (rd_data),
        .o_mdu_start    (mdu_start),
        .o_mdu_ctrl     (mdu_ctrl),
        .o_mdu_a        (mdu_A),
        .o_mdu_b        (mdu_B),
        .i_mdu_busy     (mdu_busy),
        .i_mdu_hi       (mdu_HI),
        .i_mdu_lo       (mdu_LO)
    );

    // Architectural HI/LO effect of one operation; returns {hi, lo}.
    function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
        logic [63:0] p;
        p = {hi, lo};
        case (op)
            mtMultiply:         p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            mtMultiplyUnsigned: p = {32'd0, a} * {32'd0, b};
            mtDivide:           p = (b == 0) ? {a, 32'hFFFFFFFF}
                                             : {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            mtDivideUnsigned:   p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            mtSetHI:            p = {a, lo};
            mtSetLO:            p = {hi, a};
            default:            p = {hi, lo};
        endcase
        return p;
    endfunction

    // Behavioural MDU: mthi/mtlo write at the start edge, mult/div run a few cycles.
    int          busy_cnt;
    logic [63:0] res;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_busy <= 1'b0;
            busy_cnt <= 0;
            mdu_HI   <= 32'd0;
            mdu_LO   <= 32'd0;
            res      <= 64'd0;
        end else if (mdu_start) begin
            if (mdu_ctrl == mtSetHI)      mdu_HI <= mdu_A;
            else if (mdu_ctrl == mtSetLO) mdu_LO <= mdu_A;
            else begin
                res      <= calc(mdu_ctrl, mdu_A, mdu_B, mdu_HI, mdu_LO);
                mdu_busy <= 1'b1;
                busy_cnt <= 2 + int'($urandom_range(0, 3));
            end
        end else if (mdu_busy) begin
            if (busy_cnt <= 1) begin
                mdu_busy <= 1'b0;
                {mdu_HI, mdu_LO} <= res;
            end
            busy_cnt <= busy_cnt - 1;
        end
    end

    // One EX cycle, entered and left at posedge+1. Model: a 1-deep queue that
    // accepts when empty or when its head leaves this cycle.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a, b,
                        input logic rd, rhi, fl, output logic s, output logic [31:0] rdv);
        logic req, can_issue, acc, exp_stall;
        logic [31:0] exp_rd;
        op_t e;
        ex_mdu_valid = v; ex_op = op; ex_a = a; ex_b = b;
        ex_hilo_read = rd; ex_read_hi = rhi; flush = fl;
        #3;
        req       = v && !fl && (op inside {mtMultiply, mtMultiplyUnsigned, mtDivide,
                                            mtDivideUnsigned, mtSetHI, mtSetLO});
        can_issue = !mdu_busy && !m_start;
        acc       = req && (q.size() == 0 || can_issue);
        exp_stall = (req && !acc) || (rd && !fl && (mdu_busy || m_start || q.size() != 0));
        checks++;
        if (stall !== exp_stall)
            begin errors++; $display("FAIL stall t=%0t got=%b exp=%b", $time, stall, exp_stall); end
        checks++;
        if (mdu_start === 1'b1 && mdu_busy === 1'b1)
            begin errors++; $display("FAIL start_while_busy t=%0t got=1 exp=0", $time); end
        rdv = rd_data;
        if (rd && !fl && !exp_stall) begin
            exp_rd = rhi ? arch_hi : arch_lo;
            checks++;
            if (rd_data !== exp_rd)
                begin errors++; $display("FAIL rd_data t=%0t got=%h exp=%h", $time, rd_data, exp_rd); end
        end
        if (acc) begin
            e = '{op, a, b};
            q.push_back(e);
            {arch_hi, arch_lo} = calc(op, a, b, arch_hi, arch_lo);
        end
        m_start = 1'b0;
        if (can_issue && q.size() != 0) begin
            e = q.pop_front();
            m_start = 1'b1; m_ctrl = e.op; m_a = e.a; m_b = e.b;
        end
        s = exp_stall;
        @(posedge clk); #1;
        checks++;
        if ({mdu_start, mdu_ctrl, mdu_A, mdu_B} !== {m_start, m_ctrl, m_a, m_b})
            begin errors++; $display("FAIL issue_regs t=%0t got=%b/%0d/%h/%h exp=%b/%0d/%h/%h",
                $time, mdu_start, mdu_ctrl, mdu_A, mdu_B, m_start, m_ctrl, m_a, m_b); end
    endtask

    // Present one instruction, re-presenting it while the model says EX is stalled.
    task automatic run_instr(input logic v, input logic [2:0] op, input logic [31:0] a, b,
                             input logic rd, rhi, fl, output int nst, output logic [31:0] rdv);
        logic s;
        nst = 0;
        step(v, op, a, b, rd, rhi, fl, s, rdv);
        while (s) begin
            nst++;
            if (nst > 100) begin
                errors++; $display("FAIL stall_timeout got=%0d exp<=100", nst);
                break;
            end
            step(v, op, a, b, rd, rhi, fl, s, rdv);
        end
    endtask

    task automatic idle();
        logic s; logic [31:0] r;
        step(1'b0, mtNone, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, s, r);
    endtask

    task automatic drain();
        int n = 0;
        while ((mdu_busy || m_start || q.size() != 0) && n < 100) begin idle(); n++; end
        if (n >= 100) begin errors++; $display("FAIL drain_timeout got=%0d exp<100", n); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ex_mdu_valid = 1'b0; ex_op = mtNone; ex_a = 32'd0; ex_b = 32'd0;
        ex_hilo_read = 1'b0; ex_read_hi = 1'b0; flush = 1'b0;
        #3;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (mdu_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", mdu_start); end
        checks++; if (mdu_ctrl !== 3'd0) begin errors++; $display("FAIL reset_ctrl got=%0d exp=0", mdu_ctrl); end
        checks++; if ({mdu_A, mdu_B} !== 64'd0) begin errors++; $display("FAIL reset_ab got=%h exp=0", {mdu_A, mdu_B}); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_bypass();
        int nst; logic s; logic [31:0] r;
        drain();
        step(1'b1, mtMultiply, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 1'b0, s, r);
        checks++;
        if (mdu_start !== 1'b1 || mdu_ctrl !== mtMultiply)
            begin errors++; $display("FAIL bypass_start got=%b/%0d exp=1/%0d", mdu_start, mdu_ctrl, mtMultiply); end
        run_instr(1'b0, mtNone, 0, 0, 1'b1, 1'b0, 1'b0, nst, r);
        checks++; if (nst < 1) begin errors++; $display("FAIL bypass_mflo_stalls got=%0d exp>=1", nst); end
        checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL bypass_lo got=%h exp=fffffffe", r); end
        run_instr(1'b0, mtNone, 0, 0, 1'b1, 1'b1, 1'b0, nst, r);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL bypass_hi got=%h exp=ffffffff", r); end
    endtask

    task automatic test_ordering();
        int nst, n; logic s; logic [31:0] r;
        drain();
        step(1'b1, mtDivide, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0, s, r);
        step(1'b1, mtSetHI, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0, s, r);
        checks++; if (mdu_start !== 1'b0) begin errors++; $display("FAIL order_held got=%b exp=0", mdu_start); end
        n = 0;
        while (mdu_start !== 1'b1 && n < 50) begin idle(); n++; end
        checks++;
        if (mdu_ctrl !== mtSetHI || mdu_busy !== 1'b0)
            begin errors++; $display("FAIL order_issue got=%0d/%b exp=%0d/0", mdu_ctrl, mdu_busy, mtSetHI); end
        run_instr(1'b0, mtNone, 0, 0, 1'b1, 1'b1, 1'b0, nst, r);
        checks++; if (r !== 32'h1234) begin errors++; $display("FAIL order_hi got=%h exp=1234", r); end
        run_instr(1'b0, mtNone, 0, 0, 1'b1, 1'b0, 1'b0, nst, r);
        checks++; if (r !== 32'd3) begin errors++; $display("FAIL order_lo got=%h exp=3", r); end
    endtask

    task automatic test_slot_full();
        int n1, n2, n3; logic [31:0] r;
        drain();
        run_instr(1'b1, mtMultiplyUnsigned, 32'd10, 32'd20, 1'b0, 1'b0, 1'b0, n1, r);
        run_instr(1'b1, mtMultiply, 32'd3, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, n2, r);
        run_instr(1'b1, mtMultiply, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, n3, r);
        checks++;
        if (n1 != 0 || n2 != 0 || n3 < 1)
            begin errors++; $display("FAIL slot_full_stalls got=%0d/%0d/%0d exp=0/0/>=1", n1, n2, n3); end
        run_instr(1'b0, mtNone, 0, 0, 1'b1, 1'b0, 1'b0, n1, r);
        checks++; if (r !== 32'd30) begin errors++; $display("FAIL slot_full_lo got=%h exp=1e", r); end
    endtask

    task automatic test_mt_read();
        int nst; logic [31:0] r;
        drain();
        run_instr(1'b1, mtSetLO, 32'hCAFE, 32'd0, 1'b0, 1'b0, 1'b0, nst, r);
        run_instr(1'b0, mtNone, 0, 0, 1'b1, 1'b0, 1'b0, nst, r);
        checks++; if (nst != 1) begin errors++; $display("FAIL mtlo_stall got=%0d exp=1", nst); end
        checks++; if (r !== 32'hCAFE) begin errors++; $display("FAIL mtlo_data got=%h exp=cafe", r); end
    endtask

    task automatic test_flush();
        logic s; logic [31:0] r;
        drain();
        step(1'b1, mtMultiply, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, s, r);
        checks++; if (mdu_start !== 1'b0) begin errors++; $display("FAIL flush_op got=%b exp=0", mdu_start); end
        idle();
        checks++; if (mdu_start !== 1'b0) begin errors++; $display("FAIL flush_slot got=%b exp=0", mdu_start); end
        step(1'b1, mtDivideUnsigned, 32'd9, 32'd0, 1'b0, 1'b0, 1'b0, s, r);
        idle();
        ex_hilo_read = 1'b1; ex_read_hi = 1'b0; flush = 1'b1; #3;
        checks++;
        if (mdu_busy !== 1'b1 || stall !== 1'b0)
            begin errors++; $display("FAIL flush_read got=busy%b/stall%b exp=busy1/stall0", mdu_busy, stall); end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_reset_mid();
        logic s; logic [31:0] r; int starts = 0;
        drain();
        step(1'b1, mtDivide, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, s, r);
        step(1'b1, mtMultiply, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, s, r);
        ex_mdu_valid = 1'b0; ex_hilo_read = 1'b0; flush = 1'b0;
        #2 rst_n = 1'b0; #1;
        checks++;
        if ({mdu_start, mdu_ctrl, mdu_A, mdu_B} !== 68'd0)
            begin errors++; $display("FAIL reset_mid got=%b/%0d/%h/%h exp=0/0/0/0", mdu_start, mdu_ctrl, mdu_A, mdu_B); end
        q.delete(); m_start = 1'b0; m_ctrl = 3'd0; m_a = 32'd0; m_b = 32'd0;
        arch_hi = 32'd0; arch_lo = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin idle(); if (mdu_start === 1'b1) starts++; end
        checks++; if (starts != 0) begin errors++; $display("FAIL reset_discard got=%0d exp=0", starts); end
    endtask

    task automatic test_random();
        int nst; logic [31:0] r, a, b; logic [2:0] op; int k;
        for (int i = 0; i < 400; i++) begin
            k  = int'($urandom_range(0, 9));
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (op == mtDivide || op == mtDivideUnsigned) ? $urandom_range(0, 20) : $urandom;
            if (k <= 3)      run_instr(1'b1, op, a, b, 1'b0, 1'b0, ($urandom_range(0, 9) == 0), nst, r);
            else if (k <= 6) run_instr(1'b0, mtNone, 0, 0, 1'b1, 1'($urandom_range(0, 1)),
                                       ($urandom_range(0, 9) == 0), nst, r);
            else             idle();
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_ordering();
        test_slot_full();
        test_mt_read();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
